// File: rtl/pulse_meter.sv
// pulse_meter
//   Measures a pulse train in clock cycles. For every complete period it
//   publishes the high width and the rise-to-rise period together with a
//   one-cycle valid strobe. signal_in may be asynchronous; it passes through
//   a synchroniser chain before any edge detection.
//
// Parameters
//   CNT_W        width of the accumulators and result outputs
//   SYNC_STAGES  number of synchroniser flops on signal_in (2 or more)
//
// Ports
//   clock       rising-edge clock for all state
//   reset_n     asynchronous active-low reset
//   signal_in   pulse train to measure
//   enable      1 = measure, 0 = abort the current period and hold results
//   high_cnt    high width of the last complete period
//   period_cnt  rise-to-rise period of the last complete period
//   valid       one-cycle strobe when the results above were just updated
//   overflow    the last published measurement saturated
module pulse_meter #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             signal_in,
  input  logic             enable,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hacc;
  logic [CNT_W-1:0] hacc_nxt;
  logic [CNT_W-1:0] pacc;
  logic [CNT_W-1:0] pacc_nxt;
  logic             sat;
  logic             sat_nxt;
  logic             publish;
  logic             h_at_max;
  logic             p_at_max;

  // Synchroniser chain; bit 0 is the metastability-exposed flop, the top
  // bit is the clean sampled level. s_d holds it one more cycle so that
  // edges can be detected without an extra cycle of latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  assign h_at_max = (hacc == CNT_MAX);
  assign p_at_max = (pacc == CNT_MAX);

  // State and accumulator registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      hacc  <= '0;
      pacc  <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      hacc  <= hacc_nxt;
      pacc  <= pacc_nxt;
      sat   <= sat_nxt;
    end
  end

  // Next-state logic. The rising edge that closes a period is also cycle 1
  // of the next one, so accumulators restart at 1 rather than 0. An
  // increment attempted at the maximum value holds the count and marks the
  // measurement as saturated. Dropping enable overrides everything,
  // including a publish on the same cycle.
  always_comb begin
    state_nxt = state;
    hacc_nxt  = hacc;
    pacc_nxt  = pacc;
    sat_nxt   = sat;
    publish   = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
      hacc_nxt  = '0;
      pacc_nxt  = '0;
      sat_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = HIGH;
            hacc_nxt  = CNT_ONE;
            pacc_nxt  = CNT_ONE;
            sat_nxt   = 1'b0;
          end
        end

        HIGH: begin
          pacc_nxt = p_at_max ? pacc : pacc + CNT_ONE;
          if (s && !h_at_max) begin
            hacc_nxt = hacc + CNT_ONE;
          end
          sat_nxt = sat | p_at_max | (s & h_at_max);
          if (fall) begin
            state_nxt = LOW;
          end
        end

        LOW: begin
          if (rise) begin
            publish   = 1'b1;
            state_nxt = HIGH;
            hacc_nxt  = CNT_ONE;
            pacc_nxt  = CNT_ONE;
            sat_nxt   = 1'b0;
          end else begin
            pacc_nxt = p_at_max ? pacc : pacc + CNT_ONE;
            sat_nxt  = sat | p_at_max;
          end
        end

        default: begin
          state_nxt = IDLE;
          hacc_nxt  = '0;
          pacc_nxt  = '0;
          sat_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Result registers: loaded only on a publish, so they keep the last
  // complete measurement across aborts and idle periods.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= publish;
      if (publish) begin
        high_cnt   <= hacc;
        period_cnt <= pacc;
        overflow   <= sat;
      end
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter
//   Bench for pulse_meter. Two instances share clock, reset, enable and the
//   pulse train: an 8-bit one and a 4-bit one used for saturation behaviour.
//   Expected measurements are queued as the pulse train is driven and are
//   popped by a monitor whenever an instance strobes valid.
module tb_pulse_meter;

  localparam int SYNC = 2;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] p;
    logic       o;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       signal_in;
  logic       enable;

  logic [7:0] high8;
  logic [7:0] period8;
  logic       valid8;
  logic       ovf8;

  logic [3:0] high4;
  logic [3:0] period4;
  logic       valid4;
  logic       ovf4;

  exp_t q8[$];
  exp_t q4[$];
  int   valid8_times[$];
  int   valid8_count = 0;
  int   cyc = 0;
  bit   mon4 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pulse_meter #(.CNT_W(8), .SYNC_STAGES(SYNC)) dut8 (
    .clock     (clock),
    .reset_n   (reset_n),
    .signal_in (signal_in),
    .enable    (enable),
    .high_cnt  (high8),
    .period_cnt(period8),
    .valid     (valid8),
    .overflow  (ovf8)
  );

  pulse_meter #(.CNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
    .clock     (clock),
    .reset_n   (reset_n),
    .signal_in (signal_in),
    .enable    (enable),
    .high_cnt  (high4),
    .period_cnt(period4),
    .valid     (valid4),
    .overflow  (ovf4)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard for the 8-bit instance: every strobe must match the oldest
  // queued expectation, and a strobe with nothing queued is an error.
  always @(negedge clock) begin
    if (valid8 === 1'b1) begin
      exp_t e;
      valid8_count++;
      valid8_times.push_back(cyc);
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_valid8 got high=%0d period=%0d ovf=%0d, expected no strobe",
                 high8, period8, ovf8);
      end else begin
        e = q8.pop_front();
        if (high8 !== e.h || period8 !== e.p || ovf8 !== e.o) begin
          errors++;
          $display("[TB] FAIL result8 got high=%0d period=%0d ovf=%0d, expected high=%0d period=%0d ovf=%0d",
                   high8, period8, ovf8, e.h, e.p, e.o);
        end
      end
    end
  end

  // Scoreboard for the 4-bit instance, active only during saturation tests.
  always @(negedge clock) begin
    if (mon4 && valid4 === 1'b1) begin
      exp_t e;
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_valid4 got high=%0d period=%0d ovf=%0d, expected no strobe",
                 high4, period4, ovf4);
      end else begin
        e = q4.pop_front();
        if ({4'b0, high4} !== e.h || {4'b0, period4} !== e.p || ovf4 !== e.o) begin
          errors++;
          $display("[TB] FAIL result4 got high=%0d period=%0d ovf=%0d, expected high=%0d period=%0d ovf=%0d",
                   high4, period4, ovf4, e.h, e.p, e.o);
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    signal_in = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic push8(input int h, input int p, input logic o);
    exp_t e;
    e.h = 8'(h);
    e.p = 8'(p);
    e.o = o;
    q8.push_back(e);
  endtask

  task automatic push4(input int h, input int p, input logic o);
    exp_t e;
    e.h = 8'(h);
    e.p = 8'(p);
    e.o = o;
    q4.push_back(e);
  endtask

  task automatic do_reset;
    reset_n   = 1'b0;
    signal_in = 1'b0;
    enable    = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    signal_in = 1'b0;
    enable    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (high8 !== 8'd0 || period8 !== 8'd0 || valid8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values got high=%0d period=%0d valid=%0d ovf=%0d, expected all 0",
               high8, period8, valid8, ovf8);
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (high8 !== 8'd0 || period8 !== 8'd0 || valid8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_release got high=%0d period=%0d valid=%0d ovf=%0d, expected all 0",
               high8, period8, valid8, ovf8);
    end
  endtask

  task automatic test_period_3_10;
    int c0;
    do_reset();
    drive(1'b0, 3);
    c0 = valid8_count;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) push8(3, 10, 1'b0);
      pulse(3, 7);
    end
    drive(1'b0, SYNC + 3);
    checks++;
    if (valid8_count - c0 !== 3) begin
      errors++;
      $display("[TB] FAIL strobe_count_3_10 got %0d, expected 3", valid8_count - c0);
    end
    checks++;
    if (q8.size() !== 0) begin
      errors++;
      $display("[TB] FAIL pending_3_10 got %0d queued, expected 0", q8.size());
    end
    checks++;
    if (high8 !== 8'd3 || period8 !== 8'd10 || ovf8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_3_10 got high=%0d period=%0d ovf=%0d, expected 3/10/0",
               high8, period8, ovf8);
    end
  endtask

  task automatic test_alternating;
    int c0;
    int t0;
    do_reset();
    drive(1'b0, 2);
    c0 = valid8_count;
    t0 = valid8_times.size();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) push8(1, 2, 1'b0);
      pulse(1, 1);
    end
    drive(1'b0, SYNC + 3);
    checks++;
    if (valid8_count - c0 !== 7) begin
      errors++;
      $display("[TB] FAIL strobe_count_alt got %0d, expected 7", valid8_count - c0);
    end
    for (int j = t0 + 1; j < valid8_times.size(); j++) begin
      checks++;
      if (valid8_times[j] - valid8_times[j-1] !== 2) begin
        errors++;
        $display("[TB] FAIL strobe_gap_alt got %0d cycles, expected 2",
                 valid8_times[j] - valid8_times[j-1]);
      end
    end
  endtask

  task automatic test_saturation;
    do_reset();
    mon4 = 1'b1;
    drive(1'b0, 2);
    pulse(20, 5);
    push8(20, 25, 1'b0);
    push4(15, 15, 1'b1);
    pulse(20, 5);
    push8(20, 25, 1'b0);
    push4(15, 15, 1'b1);
    pulse(2, 3);
    push8(2, 5, 1'b0);
    push4(2, 5, 1'b0);
    pulse(1, 4);
    drive(1'b0, SYNC + 2);
    checks++;
    if (q4.size() !== 0 || q8.size() !== 0) begin
      errors++;
      $display("[TB] FAIL pending_sat got q4=%0d q8=%0d, expected 0/0", q4.size(), q8.size());
    end
    checks++;
    if (high4 !== 4'd2 || period4 !== 4'd5 || ovf4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_recover got high=%0d period=%0d ovf=%0d, expected 2/5/0",
               high4, period4, ovf4);
    end
    mon4 = 1'b0;
  endtask

  task automatic test_enable_abort;
    do_reset();
    drive(1'b0, 2);
    pulse(3, 7);
    push8(3, 10, 1'b0);
    pulse(3, 7);
    push8(3, 10, 1'b0);
    drive(1'b1, 3);
    drive(1'b0, 2);
    enable = 1'b0;
    repeat (4) begin
      @(negedge clock);
      checks++;
      if (valid8 !== 1'b0 || high8 !== 8'd3 || period8 !== 8'd10) begin
        errors++;
        $display("[TB] FAIL abort_hold got valid=%0d high=%0d period=%0d, expected 0/3/10",
                 valid8, high8, period8);
      end
    end
    @(posedge clock);
    #1;
    enable = 1'b1;
    drive(1'b0, 3);
    pulse(3, 7);
    push8(3, 10, 1'b0);
    pulse(1, 4);
    drive(1'b0, SYNC + 2);
    checks++;
    if (q8.size() !== 0) begin
      errors++;
      $display("[TB] FAIL pending_abort got %0d queued, expected 0", q8.size());
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    drive(1'b0, 2);
    pulse(3, 7);
    push8(3, 10, 1'b0);
    pulse(3, 7);
    push8(3, 10, 1'b0);
    drive(1'b1, 4);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (high8 !== 8'd0 || period8 !== 8'd0 || valid8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got high=%0d period=%0d valid=%0d ovf=%0d, expected all 0",
               high8, period8, valid8, ovf8);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 3);
    drive(1'b0, 7);
    push8(3, 10, 1'b0);
    pulse(1, 4);
    drive(1'b0, SYNC + 2);
    checks++;
    if (q8.size() !== 0) begin
      errors++;
      $display("[TB] FAIL pending_reset got %0d queued, expected 0", q8.size());
    end
  endtask

  task automatic test_sync_latency;
    int k;
    int n0;
    do_reset();
    drive(1'b0, 3);
    pulse(1, 4);
    push8(1, 5, 1'b0);
    k  = cyc;
    n0 = valid8_times.size();
    drive(1'b1, 1);
    drive(1'b0, SYNC + 3);
    checks++;
    if (valid8_times.size() !== n0 + 1) begin
      errors++;
      $display("[TB] FAIL latency_count got %0d strobes, expected 1", valid8_times.size() - n0);
    end else begin
      checks++;
      if (valid8_times[n0] !== k + 1 + SYNC) begin
        errors++;
        $display("[TB] FAIL latency got cycle %0d, expected cycle %0d", valid8_times[n0], k + 1 + SYNC);
      end
    end
    checks++;
    if (q8.size() !== 0) begin
      errors++;
      $display("[TB] FAIL pending_latency got %0d queued, expected 0", q8.size());
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    signal_in = 1'b0;
    enable    = 1'b0;
    test_reset();
    test_period_3_10();
    test_alternating();
    test_saturation();
    test_enable_abort();
    test_async_reset();
    test_sync_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog got timeout, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
